// File: rtl/ex_hilo_mac_pkg.sv
// Shared opcode encodings and FSM state type for the EX-stage HI/LO multiply unit.
// Opcode values match the decoder's aluop bus.
package ex_hilo_mac_pkg;

  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  localparam logic [2:0] EXE_RES_MUL  = 3'b101;

  typedef enum logic [0:0] {
    MAC_IDLE = 1'b0,
    MAC_ACC  = 1'b1
  } mac_state_t;

endpackage

// File: rtl/ex_hilo_mac_mul_32x32.sv
// Combinational full-width multiplier; signed_i selects sign- or zero-extension of operands.
module mul_32x32 #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                signed_i,
  output logic [2*DATA_W-1:0] product
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  // Extending to 2*DATA_W first makes the truncated product exact in both modes.
  always_comb begin
    if (signed_i) begin
      a_ext = {{DATA_W{a[DATA_W-1]}}, a};
      b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    end else begin
      a_ext = {{DATA_W{1'b0}}, a};
      b_ext = {{DATA_W{1'b0}}, b};
    end
    product = a_ext * b_ext;
  end

endmodule

// File: rtl/ex_hilo_mac.sv
// EX-stage multiply / HI-LO unit: owns HI/LO, single-cycle MULT/MUL/MFxx/MTxx,
// two-cycle MADD/MSUB family with a stall request on the first cycle.
module ex_hilo_mac
  import ex_hilo_mac_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AOP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AOP_W-1:0]  aluop,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [4:0]        w_addr_i,
  input  logic              we_i,
  input  logic              ex_stall,
  output logic              own_o,
  output logic [DATA_W-1:0] w_data,
  output logic [4:0]        w_addr,
  output logic              we,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq
);

  localparam logic [AOP_W-1:0] OP_MFHI  = AOP_W'(EXE_MFHI_OP);
  localparam logic [AOP_W-1:0] OP_MTHI  = AOP_W'(EXE_MTHI_OP);
  localparam logic [AOP_W-1:0] OP_MFLO  = AOP_W'(EXE_MFLO_OP);
  localparam logic [AOP_W-1:0] OP_MTLO  = AOP_W'(EXE_MTLO_OP);
  localparam logic [AOP_W-1:0] OP_MULT  = AOP_W'(EXE_MULT_OP);
  localparam logic [AOP_W-1:0] OP_MULTU = AOP_W'(EXE_MULTU_OP);
  localparam logic [AOP_W-1:0] OP_MADD  = AOP_W'(EXE_MADD_OP);
  localparam logic [AOP_W-1:0] OP_MADDU = AOP_W'(EXE_MADDU_OP);
  localparam logic [AOP_W-1:0] OP_MUL   = AOP_W'(EXE_MUL_OP);
  localparam logic [AOP_W-1:0] OP_MSUB  = AOP_W'(EXE_MSUB_OP);
  localparam logic [AOP_W-1:0] OP_MSUBU = AOP_W'(EXE_MSUBU_OP);

  mac_state_t          state;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [2*DATA_W-1:0] prod_q;
  logic                sub_q;

  logic                own;
  logic                op_signed;
  logic                op_mult;
  logic                op_mac;
  logic                op_sub;
  logic                op_gpr;
  logic [2*DATA_W-1:0] product;
  logic [2*DATA_W-1:0] acc_next;

  always_comb begin
    own       = 1'b0;
    op_signed = 1'b0;
    op_mult   = 1'b0;
    op_mac    = 1'b0;
    op_sub    = 1'b0;
    op_gpr    = 1'b0;
    case (aluop)
      OP_MULT:  begin own = 1'b1; op_signed = 1'b1; op_mult = 1'b1; end
      OP_MULTU: begin own = 1'b1; op_mult = 1'b1; end
      OP_MUL:   begin own = 1'b1; op_signed = 1'b1; op_gpr = 1'b1; end
      OP_MFHI:  begin own = 1'b1; op_gpr = 1'b1; end
      OP_MFLO:  begin own = 1'b1; op_gpr = 1'b1; end
      OP_MTHI:  own = 1'b1;
      OP_MTLO:  own = 1'b1;
      OP_MADD:  begin own = 1'b1; op_signed = 1'b1; op_mac = 1'b1; end
      OP_MADDU: begin own = 1'b1; op_mac = 1'b1; end
      OP_MSUB:  begin own = 1'b1; op_signed = 1'b1; op_mac = 1'b1; op_sub = 1'b1; end
      OP_MSUBU: begin own = 1'b1; op_mac = 1'b1; op_sub = 1'b1; end
      default:  own = 1'b0;
    endcase
  end

  mul_32x32 #(.DATA_W(DATA_W)) u_mul (
    .a        (reg1),
    .b        (reg2),
    .signed_i (op_signed),
    .product  (product)
  );

  // The add/subtract direction is latched at acceptance, so ACC never depends on aluop.
  assign acc_next = sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MAC_IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      prod_q <= '0;
      sub_q  <= 1'b0;
    end else if (!ex_stall) begin
      case (state)
        MAC_IDLE: begin
          if (op_mac) begin
            prod_q <= product;
            sub_q  <= op_sub;
            state  <= MAC_ACC;
          end else if (op_mult) begin
            hi_q <= product[2*DATA_W-1:DATA_W];
            lo_q <= product[DATA_W-1:0];
          end else if (aluop == OP_MTHI) begin
            hi_q <= reg1;
          end else if (aluop == OP_MTLO) begin
            lo_q <= reg1;
          end
        end
        MAC_ACC: begin
          hi_q  <= acc_next[2*DATA_W-1:DATA_W];
          lo_q  <= acc_next[DATA_W-1:0];
          state <= MAC_IDLE;
        end
        default: state <= MAC_IDLE;
      endcase
    end
  end

  always_comb begin
    w_data = '0;
    if (!rst) begin
      if (aluop == OP_MUL)       w_data = product[DATA_W-1:0];
      else if (aluop == OP_MFHI) w_data = hi_q;
      else if (aluop == OP_MFLO) w_data = lo_q;
    end
  end

  assign own_o    = own;
  assign w_addr   = w_addr_i;
  assign we       = !rst && we_i && op_gpr;
  assign stallreq = !rst && (state == MAC_IDLE) && op_mac;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: tb/tb_ex_hilo_mac.sv
// Directed self-checking bench for ex_hilo_mac with hand-computed expectations.
module tb_ex_hilo_mac;
  import ex_hilo_mac_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  w_addr_i;
  logic        we_i;
  logic        ex_stall;
  logic        own_o;
  logic [31:0] w_data;
  logic [4:0]  w_addr;
  logic        we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq;

  int total = 0;
  int bad   = 0;

  ex_hilo_mac #(.DATA_W(32), .AOP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .aluop    (aluop),
    .reg1     (reg1),
    .reg2     (reg2),
    .w_addr_i (w_addr_i),
    .we_i     (we_i),
    .ex_stall (ex_stall),
    .own_o    (own_o),
    .w_data   (w_data),
    .w_addr   (w_addr),
    .we       (we),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .stallreq (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic wen, input logic [4:0] wa);
    aluop    = op;
    reg1     = a;
    reg2     = b;
    we_i     = wen;
    w_addr_i = wa;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ex_stall = 1'b0;
    applyStimulus(EXE_MUL_OP, 32'd3, 32'd4, 1'b1, 5'd9);
    tick();
    tick();
    #1;
    checkOutput("rst_hi", hi_o, 32'h0);
    checkOutput("rst_lo", lo_o, 32'h0);
    checkOutput("rst_stallreq", 32'(stallreq), 32'h0);
    checkOutput("rst_we", 32'(we), 32'h0);
    checkOutput("rst_wdata", w_data, 32'h0);
    rst = 1'b0;

    applyStimulus(EXE_MULT_OP, 32'hFFFF_FFFF, 32'd2, 1'b0, 5'd0);
    checkOutput("mult_own", 32'(own_o), 32'h1);
    checkOutput("mult_we", 32'(we), 32'h0);
    tick();
    checkOutput("mult_hi", hi_o, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo_o, 32'hFFFF_FFFE);
    applyStimulus(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2, 1'b0, 5'd0);
    tick();
    checkOutput("multu_hi", hi_o, 32'h1);
    checkOutput("multu_lo", lo_o, 32'hFFFF_FFFE);

    applyStimulus(EXE_MUL_OP, 32'd7, 32'hFFFF_FFFD, 1'b1, 5'd5);
    checkOutput("mul_wdata", w_data, 32'hFFFF_FFEB);
    checkOutput("mul_we", 32'(we), 32'h1);
    checkOutput("mul_waddr", 32'(w_addr), 32'd5);
    tick();
    checkOutput("mul_hi_kept", hi_o, 32'h1);
    checkOutput("mul_lo_kept", lo_o, 32'hFFFF_FFFE);

    applyStimulus(8'h25, 32'hDEAD_BEEF, 32'h5, 1'b1, 5'd3);
    checkOutput("other_own", 32'(own_o), 32'h0);
    checkOutput("other_wdata", w_data, 32'h0);
    checkOutput("other_we", 32'(we), 32'h0);
    tick();
    checkOutput("other_hi_kept", hi_o, 32'h1);

    applyStimulus(EXE_MTHI_OP, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();
    applyStimulus(EXE_MTLO_OP, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0);
    tick();
    checkOutput("pre_maddu_hi", hi_o, 32'h0);
    checkOutput("pre_maddu_lo", lo_o, 32'hFFFF_FFFF);
    applyStimulus(EXE_MADDU_OP, 32'd1, 32'd1, 1'b0, 5'd0);
    checkOutput("maddu_c1_stall", 32'(stallreq), 32'h1);
    tick();
    checkOutput("maddu_c2_stall", 32'(stallreq), 32'h0);
    checkOutput("maddu_c2_lo_held", lo_o, 32'hFFFF_FFFF);
    tick();
    checkOutput("maddu_hi", hi_o, 32'h1);
    checkOutput("maddu_lo", lo_o, 32'h0);
    applyStimulus(EXE_MSUB_OP, 32'd1, 32'd1, 1'b0, 5'd0);
    checkOutput("msub_c1_stall", 32'(stallreq), 32'h1);
    tick();
    tick();
    checkOutput("msub_hi", hi_o, 32'h0);
    checkOutput("msub_lo", lo_o, 32'hFFFF_FFFF);

    applyStimulus(EXE_MTHI_OP, 32'h1234, 32'h0, 1'b0, 5'd0);
    tick();
    applyStimulus(EXE_MFHI_OP, 32'h0, 32'h0, 1'b1, 5'd7);
    checkOutput("mfhi_wdata", w_data, 32'h1234);
    checkOutput("mfhi_we", 32'(we), 32'h1);
    tick();
    applyStimulus(EXE_MTLO_OP, 32'hAAAA, 32'h0, 1'b0, 5'd0);
    tick();
    checkOutput("mtlo_hi_kept", hi_o, 32'h1234);
    checkOutput("mtlo_lo", lo_o, 32'hAAAA);
    applyStimulus(EXE_MFLO_OP, 32'h0, 32'h0, 1'b1, 5'd8);
    checkOutput("mflo_wdata", w_data, 32'hAAAA);
    tick();

    applyStimulus(EXE_MADD_OP, 32'd2, 32'd3, 1'b0, 5'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(8'h00, 32'd0, 32'd0, 1'b0, 5'd0);
    tick();
    checkOutput("abort_hi", hi_o, 32'h0);
    checkOutput("abort_lo", lo_o, 32'h0);
    applyStimulus(EXE_MADD_OP, 32'd2, 32'd3, 1'b0, 5'd0);
    checkOutput("abort_idle_stall", 32'(stallreq), 32'h1);
    tick();
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("exstall_lo_%0d", i), lo_o, 32'h0);
      checkOutput($sformatf("exstall_req_%0d", i), 32'(stallreq), 32'h0);
    end
    ex_stall = 1'b0;
    tick();
    checkOutput("exstall_commit_lo", lo_o, 32'd6);
    checkOutput("exstall_commit_hi", hi_o, 32'h0);
    applyStimulus(8'h00, 32'd0, 32'd0, 1'b0, 5'd0);
    tick();
    checkOutput("no_double_commit", lo_o, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
